// File: rtl/riscv_pkg.sv
// Shared types and constants for the instruction fetch path.
// A fetch entry is one instruction word tagged with the address it came from.
package riscv_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;
    localparam int ENTRY_W = INSTR_W + XLEN;

    localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0]    DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [XLEN-1:0]    pc;
    } fetch_entry_t;

    // Force an address onto a 32-bit word boundary.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with a flush that outranks push.
// The head entry is read straight out of storage, so it is a registered value.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
)(
    input  logic               clk,
    input  logic               rstn,
    input  logic               push,
    input  logic [ENTRY_W-1:0] push_data,
    input  logic               pop,
    input  logic               flush,
    output logic [CW-1:0]      count,
    output logic [ENTRY_W-1:0] head
);

    logic [ENTRY_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]      wr_ptr_r;
    logic [AW-1:0]      rd_ptr_r;
    logic [CW-1:0]      count_r;
    logic               do_push_s;
    logic               do_pop_s;

    // Qualify requests: never pop empty, only push into full alongside a pop.
    always_comb begin
        do_pop_s  = pop && (count_r != {CW{1'b0}});
        do_push_s = push && ((count_r != CW'(DEPTH)) || do_pop_s);
    end

    // Pointer and occupancy tracking; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; cleared on reset so the head reads as zero afterwards.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {ENTRY_W{1'b0}};
            end
        end else if (!flush && do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign count = count_r;
    assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch unit: owns the PC, issues fixed-latency memory reads and
// buffers returned words for decode; a redirect flushes everything and restarts.
module fetch_queue
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 4
)(
    input  logic        clk,
    input  logic        rstn,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0]    pc_r;
    logic [XLEN-1:0]    req_pc_r;
    logic               inflight_r;
    logic               active_r;
    logic [CW-1:0]      count_s;
    logic [ENTRY_W-1:0] head_s;
    fetch_entry_t       head_entry_s;
    fetch_entry_t       push_entry_s;
    logic               credit_s;
    logic               kill_s;
    logic               req_s;
    logic               push_s;
    logic               pop_s;
    logic               valid_s;

    // Issue credit counts in-flight reads so a response always finds room;
    // active_r holds off the first request until the cycle after reset release.
    always_comb begin
        kill_s             = redirect_valid;
        credit_s           = ({1'b0, count_s} + {{CW{1'b0}}, inflight_r}) < (CW + 1)'(DEPTH);
        req_s              = active_r && !redirect_valid && credit_s;
        push_s             = inflight_r && !kill_s;
        valid_s            = (count_s != {CW{1'b0}}) && !redirect_valid;
        pop_s              = valid_s && instr_ready;
        push_entry_s.instr = imem_rdata;
        push_entry_s.pc    = req_pc_r;
        head_entry_s       = fetch_entry_t'(head_s);
    end

    // PC, request tracking and the post-reset start flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_r       <= align_word(RESET_PC);
            req_pc_r   <= 32'h0000_0000;
            inflight_r <= 1'b0;
            active_r   <= 1'b0;
        end else begin
            active_r   <= 1'b1;
            inflight_r <= req_s;
            if (redirect_valid) begin
                pc_r <= align_word(redirect_pc);
            end else if (req_s) begin
                pc_r <= pc_r + 32'd4;
            end
            if (req_s) begin
                req_pc_r <= pc_r;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push_s),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .flush     (redirect_valid),
        .count     (count_s),
        .head      (head_s)
    );

    assign imem_req    = req_s;
    assign imem_addr   = pc_r;
    assign instr_valid = valid_s;
    assign instr       = head_entry_s.instr;
    assign instr_pc    = head_entry_s.pc;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: memory returns addr ^ 32'hA5A5_0000 one cycle
// after each request; outputs are sampled 1 time unit after the falling edge.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rstn;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0000_0000;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        saw_400 = 1'b0;

    int          n_checks = 0;
    int          n_errors = 0;
    int          nreq;
    logic [31:0] addrs [8];

    fetch_queue #(
        .RESET_PC (32'h0000_0100),
        .DEPTH    (4)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
    );

    always #5 clk = ~clk;

    // One-cycle-latency instruction memory model.
    always @(posedge clk) begin
        if (imem_req) begin
            imem_rdata <= imem_addr ^ 32'hA5A5_0000;
            if (imem_addr == 32'h0000_0400) begin
                saw_400 <= 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0000_0000;
        instr_ready    = 1'b1;
        nreq           = 0;
        for (int i = 0; i < 8; i++) addrs[i] = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_req",   {31'b0, imem_req},    32'd0);
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_instr", instr,                32'h0);
        check("rst_pc",    instr_pc,             32'h0);

        // Release and stream with ready high
        @(negedge clk); rstn = 1'b1;
        @(negedge clk); #1;
        check("c1_req",  {31'b0, imem_req}, 32'd1);
        check("c1_addr", imem_addr,         32'h0000_0100);
        @(negedge clk); #1;
        check("c2_valid", {31'b0, instr_valid}, 32'd0);
        check("c2_addr",  imem_addr,            32'h0000_0104);
        @(negedge clk); #1;
        check("c3_valid", {31'b0, instr_valid}, 32'd1);
        check("c3_pc",    instr_pc,             32'h0000_0100);
        check("c3_instr", instr,                32'hA5A5_0100);
        @(negedge clk); #1;
        check("c4_valid", {31'b0, instr_valid}, 32'd1);
        check("c4_pc",    instr_pc,             32'h0000_0104);
        @(negedge clk); #1;
        check("c5_valid", {31'b0, instr_valid}, 32'd1);
        check("c5_pc",    instr_pc,             32'h0000_0108);
        check("c5_req",   {31'b0, imem_req},    32'd1);

        // Redirect to 0 with ready low: fill then stall
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'h0; instr_ready = 1'b0;
        #1;
        check("fill_r_valid", {31'b0, instr_valid}, 32'd0);
        check("fill_r_req",   {31'b0, imem_req},    32'd0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); redirect_valid = 1'b0; #1;
            if (imem_req) begin
                if (nreq < 8) addrs[nreq] = imem_addr;
                nreq++;
            end
        end
        check("fill_nreq",  nreq,                 32'd4);
        check("fill_a0",    addrs[0],             32'h0);
        check("fill_a1",    addrs[1],             32'h4);
        check("fill_a2",    addrs[2],             32'h8);
        check("fill_a3",    addrs[3],             32'hC);
        check("full_req",   {31'b0, imem_req},    32'd0);
        check("full_valid", {31'b0, instr_valid}, 32'd1);
        check("full_pc",    instr_pc,             32'h0);
        check("full_instr", instr,                32'hA5A5_0000);

        // Drain in order with no gap or duplicate
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); instr_ready = 1'b1; #1;
            check("drain_valid", {31'b0, instr_valid}, 32'd1);
            check("drain_pc",    instr_pc,             32'(k * 4));
        end

        // Redirect with 2 queued + 1 in flight
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h0000_2002; #1;
        check("rd1_r_valid", {31'b0, instr_valid}, 32'd0);
        @(negedge clk); redirect_valid = 1'b0; #1;
        check("rd1_1_valid", {31'b0, instr_valid}, 32'd0);
        check("rd1_1_req",   {31'b0, imem_req},    32'd1);
        check("rd1_1_addr",  imem_addr,            32'h0000_2000);
        @(negedge clk); #1;
        check("rd1_2_valid", {31'b0, instr_valid}, 32'd0);
        @(negedge clk); #1;
        check("rd1_3_valid", {31'b0, instr_valid}, 32'd1);
        check("rd1_3_pc",    instr_pc,             32'h0000_2000);
        check("rd1_3_instr", instr,                32'hA5A5_2000);

        // Back-to-back redirects, last one wins
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h0000_0400; #1;
        check("b2b_r1_req", {31'b0, imem_req}, 32'd0);
        @(negedge clk); redirect_pc = 32'h0000_0800; #1;
        check("b2b_r2_req",   {31'b0, imem_req},    32'd0);
        check("b2b_r2_valid", {31'b0, instr_valid}, 32'd0);
        @(negedge clk); redirect_valid = 1'b0; #1;
        check("b2b_1_req",  {31'b0, imem_req}, 32'd1);
        check("b2b_1_addr", imem_addr,         32'h0000_0800);
        @(negedge clk); #1;
        check("b2b_2_valid", {31'b0, instr_valid}, 32'd0);
        @(negedge clk); #1;
        check("b2b_3_valid", {31'b0, instr_valid}, 32'd1);
        check("b2b_3_pc",    instr_pc,             32'h0000_0800);
        check("b2b_no_400",  {31'b0, saw_400},     32'd0);

        // PC wrap past the top of the address space
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8; #1;
        @(negedge clk); redirect_valid = 1'b0; #1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        check("wrap_pc0", instr_pc, 32'hFFFF_FFF8);
        @(negedge clk); #1;
        check("wrap_pc1", instr_pc, 32'hFFFF_FFFC);
        @(negedge clk); #1;
        check("wrap_pc2",    instr_pc,             32'h0000_0000);
        check("wrap_valid",  {31'b0, instr_valid}, 32'd1);
        check("wrap_instr",  instr,                32'hA5A5_0000);

        // Asynchronous reset with entries queued
        @(negedge clk); instr_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("pre_rst_valid", {31'b0, instr_valid}, 32'd1);
        #2; rstn = 1'b0; #1;
        check("arst_valid", {31'b0, instr_valid}, 32'd0);
        check("arst_instr", instr,                32'h0);
        check("arst_pc",    instr_pc,             32'h0);
        check("arst_req",   {31'b0, imem_req},    32'd0);
        @(negedge clk); rstn = 1'b1; instr_ready = 1'b1;
        @(negedge clk); #1;
        check("rel_req",  {31'b0, imem_req}, 32'd1);
        check("rel_addr", imem_addr,         32'h0000_0100);
        @(negedge clk); #1;
        check("rel_2_valid", {31'b0, instr_valid}, 32'd0);
        @(negedge clk); #1;
        check("rel_3_valid", {31'b0, instr_valid}, 32'd1);
        check("rel_3_pc",    instr_pc,             32'h0000_0100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch unit and fetch buffer that produces the 32-bit instruction stream consumed by the decode stage. It owns the PC, issues word reads to a fixed-latency instruction memory, and queues returned words with their PCs in a small FIFO. Entries are presented to decode over a valid/ready handshake. A redirect port from branch resolution flushes queued and in-flight fetches and restarts at a new PC.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `DEPTH`, default 4: FIFO entries; power of two, ≥2.
- `clk` in 1: single clock, rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `imem_req` out 1: read request this cycle.
- `imem_addr` out 32: word-aligned read address; bits [1:0] are always 0.
- `imem_rdata` in 32: read data, valid exactly one cycle after `imem_req`.
- `redirect_valid` in 1: flush and restart.
- `redirect_pc` in 32: restart address; bits [1:0] ignored and treated as 0.
- `instr_valid` out 1: head entry is valid.
- `instr` out 32: head instruction word.
- `instr_pc` out 32: PC of the head instruction.
- `instr_ready` in 1: decode accepts the head entry this cycle.

## Operation
- State:
  - `pc`: next fetch address.
  - `inflight`: 1 bit, set when `imem_req` was high last cycle.
  - `kill`: 1 bit, marks the in-flight response for discard.
  - FIFO storage: `{instr, pc}`, plus `count`.
- Issue:
  - `imem_req = !redirect_valid && (count + inflight < DEPTH)`, using registered values only. No same-cycle pop credit.
  - `imem_addr = pc`.
  - On issue, `pc <= pc + 4`. Wraps from 32'hFFFF_FFFC to 0.
- Response:
  - When `inflight` is set and `kill` is clear, push `{imem_rdata, pc_of_request}` into the FIFO.
  - The request PC is held in a register captured at issue.
- Output:
  - `instr_valid = (count != 0) && !redirect_valid`.
  - `instr` and `instr_pc` are driven from the head entry.
  - Pop when `instr_valid && instr_ready`.
- Push and pop in the same cycle:
  - Legal at any count, including full; count is unchanged.
  - The issue credit guarantees a push never targets a full FIFO without a simultaneous pop.
  - With count 0 there is no bypass: the pushed word appears next cycle.
- Redirect (cycle R, `redirect_valid=1`):
  - FIFO cleared at the R edge.
  - `pc <= {redirect_pc[31:2], 2'b00}`.
  - No request in R.
  - Any response arriving in R is discarded.
  - If a request was issued in R-1, its response in R is dropped. If that request was issued in R, none exists because of suppression.
  - `kill` is therefore only needed when redirect and a response coincide. It is defined as: response discarded whenever `redirect_valid` is high in its arrival cycle.
  - Fetch resumes in R+1 at `redirect_pc`.
- Back-to-back redirects: the last one wins. No request is issued in any redirect cycle.
- Reset (async, any time, including mid-fetch or mid-redirect):
  - `pc=RESET_PC`, `count=0`, `inflight=0`.
  - `imem_req=0`, `instr_valid=0`, `instr=0`, `instr_pc=0`.
  - A pending memory response after reset release is ignored because `inflight=0`.

## Timing
- Reset release at edge E0: `imem_req=1`, `imem_addr=RESET_PC` in the cycle after E0 (C1).
- Data for C1 is returned in C2 and pushed at the end of C2. `instr_valid=1` in C3.
- Fetch-to-valid latency: 2 cycles.
- With `instr_ready` held high: one instruction per cycle sustained, steady state count=1, inflight=1.
- With `instr_ready` held low: requests stop once count+inflight reaches DEPTH. Exactly DEPTH entries are held; nothing is lost.
- Redirect latency: R to first new `instr_valid` is 3 cycles (request in R+1, push in R+2, valid in R+3).

## Structure
- Shared package `riscv_pkg`:
  - `XLEN=32`
  - `INSTR_W=32`
  - `NOP_INSTR=32'h0000_0013`
  - default `RESET_PC`
  - fetch entry struct `{instr, pc}`
- Sub-module `fetch_fifo`:
  - Synchronous FIFO of DEPTH entries.
  - Ports: push, pop, flush, count, head.
  - Async active-low reset.
  - Flush has priority over push.
- Top level holds the PC, issue credit and redirect logic.

## Test plan
- Reset release, RESET_PC=0x100, ready=1, memory returns addr^0xA5A5_0000: `instr_pc` sequence 0x100, 0x104, 0x108 on consecutive cycles starting 3 cycles after release.
- ready=0 for 10 cycles after fill, DEPTH=4: exactly 4 requests (0x0..0xC), then `imem_req=0`. After ready=1, entries drain in order with no gap or duplicate.
- Redirect to 0x2002 while 2 entries are queued and 1 is in flight: all three are never presented. Next `instr_pc`=0x2000, 3 cycles after the redirect.
- Redirect on two consecutive cycles (0x400, then 0x800): no request to 0x400. First presented PC is 0x800.
- PC wrap: redirect to 0xFFFF_FFF8: presented PCs are 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Assert `rstn` low mid-stream with entries queued: outputs go to 0 asynchronously. After release the first presented PC is RESET_PC.
